// File: rtl/field_marker_if.sv
// Board settings bundle shared by the game control blocks.
interface game_set_if;
    logic [4:0] button_num;

    modport in (input button_num);
endinterface

// File: rtl/field_marker.sv
// Minefield cell-state keeper: applies click events to a dual-port board memory.
// Build option: define FIELD_QMARK_EN to add the QUESTION mark to the flag cycle.
module field_marker #(
    parameter int MAX_DIM = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    game_set_if.in     in,
    input  logic       bomb,
    input  logic       flag,
    input  logic [4:0] button_index_x,
    input  logic [4:0] button_index_y,
    input  logic       new_game,
    input  logic [7:0] mine_count,
    input  logic [4:0] rd_x,
    input  logic [4:0] rd_y,
    output logic [1:0] rd_state,
    output logic       reveal_valid,
    output logic [4:0] reveal_x,
    output logic [4:0] reveal_y,
    output logic [7:0] flags_left,
    output logic       busy
);
    localparam int IDX_W  = $clog2(MAX_DIM);
    localparam int ADDR_W = 2 * IDX_W;
    localparam int DEPTH  = MAX_DIM * MAX_DIM;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] CELL_HIDDEN   = 2'b00;
    localparam logic [1:0] CELL_FLAGGED  = 2'b01;
    localparam logic [1:0] CELL_REVEALED = 2'b10;
    localparam logic [1:0] CELL_QUESTION = 2'b11;

`ifdef FIELD_QMARK_EN
    localparam logic [1:0] UNFLAG_TO = CELL_QUESTION;
`else
    localparam logic [1:0] UNFLAG_TO = CELL_HIDDEN;
`endif

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_READ, S_WRITE} state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_next;
    logic                r_bomb_d, r_flag_d;
    logic                r_ev_bomb, w_ev_bomb_next;
    logic [4:0]          r_ev_x, r_ev_y, w_ev_x_next, w_ev_y_next;
    logic [ADDR_W-1:0]   r_ev_addr, w_ev_addr_next;
    logic [7:0]          r_flags_left, w_flags_next, w_flags_inc;
    logic                r_reveal_valid, w_reveal_next;
    logic [4:0]          r_reveal_x, r_reveal_y;
    logic [1:0]          r_mem [DEPTH];
    logic [1:0]          r_cell, w_cell, r_rd_state;
    logic                w_we_fsm, w_we;
    logic [ADDR_W-1:0]   w_waddr, w_rd_addr;
    logic [1:0]          w_wdata;
    logic [IDX_W-1:0]    w_xm1, w_ym1;
    logic                w_bomb_edge, w_flag_edge, w_in_range, w_event;
    logic                w_unused;

    assign w_bomb_edge = bomb & ~r_bomb_d;
    assign w_flag_edge = flag & ~r_flag_d;
    assign w_in_range  = (button_index_x != 5'd0) && (button_index_x <= in.button_num) &&
                         (button_index_y != 5'd0) && (button_index_y <= in.button_num);
    assign w_event     = (w_bomb_edge | w_flag_edge) & w_in_range;
    assign w_xm1       = button_index_x[IDX_W-1:0] - IDX_W'(1);
    assign w_ym1       = button_index_y[IDX_W-1:0] - IDX_W'(1);
    assign w_flags_inc = (r_flags_left < mine_count) ? r_flags_left + 8'd1 : r_flags_left;
    assign w_rd_addr   = {rd_y[IDX_W-1:0], rd_x[IDX_W-1:0]};
    assign w_unused    = ^{rd_x, rd_y};

    // Without the question mark a stray 2'b11 behaves like an untouched cell.
`ifdef FIELD_QMARK_EN
    assign w_cell = r_cell;
`else
    assign w_cell = (r_cell == CELL_QUESTION) ? CELL_HIDDEN : r_cell;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_ev_bomb_next  = r_ev_bomb;
        w_ev_x_next     = r_ev_x;
        w_ev_y_next     = r_ev_y;
        w_ev_addr_next  = r_ev_addr;
        w_flags_next    = r_flags_left;
        w_reveal_next   = 1'b0;
        w_we_fsm        = 1'b0;
        w_waddr         = r_ev_addr;
        w_wdata         = CELL_HIDDEN;

        case (r_state)
            S_CLEAR: begin
                w_we_fsm        = 1'b1;
                w_waddr         = r_clr_addr;
                w_clr_addr_next = r_clr_addr + ADDR_W'(1);
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_event) begin
                    w_ev_bomb_next = w_bomb_edge;
                    w_ev_x_next    = button_index_x;
                    w_ev_y_next    = button_index_y;
                    w_ev_addr_next = {w_ym1, w_xm1};
                    w_state_next   = S_READ;
                end
            end
            S_READ: begin
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                w_state_next = S_IDLE;
                if (r_ev_bomb) begin
                    if (w_cell == CELL_HIDDEN || w_cell == CELL_QUESTION) begin
                        w_we_fsm      = 1'b1;
                        w_wdata       = CELL_REVEALED;
                        w_reveal_next = 1'b1;
                    end
                end else begin
                    case (w_cell)
                        CELL_HIDDEN: begin
                            if (r_flags_left != 8'd0) begin
                                w_we_fsm     = 1'b1;
                                w_wdata      = CELL_FLAGGED;
                                w_flags_next = r_flags_left - 8'd1;
                            end
                        end
                        CELL_FLAGGED: begin
                            w_we_fsm     = 1'b1;
                            w_wdata      = UNFLAG_TO;
                            w_flags_next = w_flags_inc;
                        end
                        CELL_QUESTION: begin
                            w_we_fsm = 1'b1;
                            w_wdata  = CELL_HIDDEN;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                w_state_next = S_CLEAR;
            end
        endcase

        // new_game pre-empts whatever is in flight, including its write and pulse.
        if (new_game) begin
            w_state_next    = S_CLEAR;
            w_clr_addr_next = '0;
            w_flags_next    = mine_count;
            w_we_fsm        = 1'b0;
            w_reveal_next   = 1'b0;
        end
    end

    assign w_we = w_we_fsm & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_CLEAR;
            r_clr_addr     <= '0;
            r_bomb_d       <= 1'b0;
            r_flag_d       <= 1'b0;
            r_ev_bomb      <= 1'b0;
            r_ev_x         <= 5'd0;
            r_ev_y         <= 5'd0;
            r_ev_addr      <= '0;
            r_flags_left   <= 8'd0;
            r_reveal_valid <= 1'b0;
            r_reveal_x     <= 5'd0;
            r_reveal_y     <= 5'd0;
        end else begin
            r_state        <= w_state_next;
            r_clr_addr     <= w_clr_addr_next;
            r_bomb_d       <= bomb;
            r_flag_d       <= flag;
            r_ev_bomb      <= w_ev_bomb_next;
            r_ev_x         <= w_ev_x_next;
            r_ev_y         <= w_ev_y_next;
            r_ev_addr      <= w_ev_addr_next;
            r_flags_left   <= w_flags_next;
            r_reveal_valid <= w_reveal_next;
            if (w_reveal_next) begin
                r_reveal_x <= r_ev_x;
                r_reveal_y <= r_ev_y;
            end
        end
    end

    // FSM port: write plus registered read of the latched event address.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_cell <= r_mem[r_ev_addr];
    end

    // Drawing port: read-first, so a same-cycle write shows the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_state <= CELL_HIDDEN;
        end else begin
            r_rd_state <= r_mem[w_rd_addr];
        end
    end

    assign rd_state     = r_rd_state;
    assign reveal_valid = r_reveal_valid;
    assign reveal_x     = r_reveal_x;
    assign reveal_y     = r_reveal_y;
    assign flags_left   = r_flags_left;
    assign busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_field_marker.sv
// Self-checking bench for field_marker: scenario tasks plus a reveal-pulse scoreboard.
`timescale 1ns/1ps
module tb_field_marker;
    logic       clk = 1'b0;
    logic       rst_n, bomb, flag, new_game;
    logic [4:0] bx, by, rd_x, rd_y;
    logic [7:0] mine_count;
    logic [1:0] rd_state;
    logic       reveal_valid;
    logic [4:0] reveal_x, reveal_y;
    logic [7:0] flags_left;
    logic       busy;

    game_set_if gs();

    field_marker #(.MAX_DIM(16)) dut (
        .clk(clk), .rst_n(rst_n), .in(gs),
        .bomb(bomb), .flag(flag),
        .button_index_x(bx), .button_index_y(by),
        .new_game(new_game), .mine_count(mine_count),
        .rd_x(rd_x), .rd_y(rd_y), .rd_state(rd_state),
        .reveal_valid(reveal_valid), .reveal_x(reveal_x), .reveal_y(reveal_y),
        .flags_left(flags_left), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef FIELD_QMARK_EN
    localparam logic [1:0] EXP_UNFLAG = 2'b11;
`else
    localparam logic [1:0] EXP_UNFLAG = 2'b00;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;
    logic [9:0] exp_q[$];
    logic [9:0] sb_exp;

    // Scoreboard: every reveal pulse must match the oldest expected click.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && reveal_valid === 1'b1) begin
            n_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL reveal_unexpected: got (%0d,%0d) required no pulse", reveal_x, reveal_y);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({reveal_x, reveal_y} !== sb_exp)
                    $display("FAIL reveal_xy: got (%0d,%0d) required (%0d,%0d)",
                             reveal_x, reveal_y, sb_exp[9:5], sb_exp[4:0]);
                else begin
                    n_pass++;
                    $display("reveal pulse (%0d,%0d)", reveal_x, reveal_y);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic read_cell(input int x0, input int y0, output logic [1:0] v);
        rd_x = 5'(x0);
        rd_y = 5'(y0);
        @(negedge clk);
        v = rd_state;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 1000) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // One-cycle click; returns at t+3 where results are visible.
    task automatic drive_event(input logic b, input logic f, input int x, input int y);
        bx = 5'(x); by = 5'(y); bomb = b; flag = f;
        @(negedge clk);
        bomb = 1'b0; flag = 1'b0;
        repeat (2) @(negedge clk);
        $display("event bomb=%0b flag=%0b at (%0d,%0d): flags_left=%0d", b, f, x, y, flags_left);
    endtask

    task automatic do_new_game(input logic [7:0] mc, output int cycles);
        mine_count = mc; new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        wait_idle(cycles);
    endtask

    task automatic test_reset();
        int cyc, bad;
        logic [1:0] v;
        rst_n = 1'b0; bomb = 1'b0; flag = 1'b0; new_game = 1'b0;
        bx = 5'd0; by = 5'd0; rd_x = 5'd0; rd_y = 5'd0; mine_count = 8'd0;
        gs.button_num = 5'd8;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy, reveal_valid} !== 2'b10) $display("FAIL reset_busy_valid: got %b%b required 10", busy, reveal_valid); else n_pass++;
        n_checks++; if ({reveal_x, reveal_y} !== 10'd0) $display("FAIL reset_reveal_xy: got (%0d,%0d) required (0,0)", reveal_x, reveal_y); else n_pass++;
        n_checks++; if (flags_left !== 8'd0 || rd_state !== 2'b00) $display("FAIL reset_flags_rd: got %0d/%b required 0/00", flags_left, rd_state); else n_pass++;
        rst_n = 1'b1;
        wait_idle(cyc);
        n_checks++; if (cyc !== 256) $display("FAIL clear_length: got %0d required 256", cyc); else n_pass++;
        bad = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                read_cell(x, y, v);
                if (v !== 2'b00) bad++;
            end
        n_checks++; if (bad !== 0) $display("FAIL clear_cells: got %0d nonzero cells required 0", bad); else n_pass++;
        n_checks++; if (flags_left !== 8'd0) $display("FAIL clear_flags: got %0d required 0", flags_left); else n_pass++;
        $display("reset: clear took %0d cycles", cyc);
    endtask

    task automatic test_flag();
        int cyc;
        logic b1, b2, b3;
        logic [1:0] v;
        do_new_game(8'd10, cyc);
        n_checks++; if (flags_left !== 8'd10) $display("FAIL newgame_flags: got %0d required 10", flags_left); else n_pass++;
        bx = 5'd3; by = 5'd4; flag = 1'b1;
        @(negedge clk); b1 = busy; flag = 1'b0;
        @(negedge clk); b2 = busy;
        @(negedge clk); b3 = busy;
        n_checks++; if ({b1, b2, b3} !== 3'b110) $display("FAIL flag_busy: got %b required 110", {b1, b2, b3}); else n_pass++;
        n_checks++; if (flags_left !== 8'd9) $display("FAIL flag_count: got %0d required 9", flags_left); else n_pass++;
        read_cell(2, 3, v);
        n_checks++; if (v !== 2'b01) $display("FAIL flag_cell: got %b required 01", v); else n_pass++;
        $display("flag (3,4): flags_left=%0d cell=%b", flags_left, v);
    endtask

    task automatic test_bomb_held();
        int base;
        logic [1:0] v;
        base = n_pulses;
        exp_q.push_back({5'd5, 5'd5});
        bx = 5'd5; by = 5'd5; bomb = 1'b1;
        repeat (20) @(negedge clk);
        bomb = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (n_pulses - base !== 1) $display("FAIL held_pulses: got %0d required 1", n_pulses - base); else n_pass++;
        read_cell(4, 4, v);
        n_checks++; if (v !== 2'b10) $display("FAIL held_cell: got %b required 10", v); else n_pass++;
        $display("held bomb (5,5): pulses=%0d cell=%b", n_pulses - base, v);
    endtask

    task automatic test_flag_bomb();
        int base;
        logic [1:0] v;
        drive_event(1'b0, 1'b1, 2, 2);
        n_checks++; if (flags_left !== 8'd8) $display("FAIL fb_flag_count: got %0d required 8", flags_left); else n_pass++;
        base = n_pulses;
        drive_event(1'b1, 1'b0, 2, 2);
        @(negedge clk);
        n_checks++; if (n_pulses !== base) $display("FAIL fb_no_pulse: got %0d pulses required 0", n_pulses - base); else n_pass++;
        read_cell(1, 1, v);
        n_checks++; if (v !== 2'b01) $display("FAIL fb_cell_flagged: got %b required 01", v); else n_pass++;
        drive_event(1'b0, 1'b1, 2, 2);
        read_cell(1, 1, v);
        n_checks++; if (v !== EXP_UNFLAG) $display("FAIL fb_unflag_cell: got %b required %b", v, EXP_UNFLAG); else n_pass++;
        n_checks++; if (flags_left !== 8'd9) $display("FAIL fb_unflag_count: got %0d required 9", flags_left); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int base;
        logic [1:0] v;
        base = n_pulses;
        exp_q.push_back({5'd1, 5'd1});
        drive_event(1'b1, 1'b1, 1, 1);
        @(negedge clk);
        n_checks++; if (n_pulses - base !== 1) $display("FAIL simul_pulse: got %0d required 1", n_pulses - base); else n_pass++;
        n_checks++; if (flags_left !== 8'd9) $display("FAIL simul_flags: got %0d required 9", flags_left); else n_pass++;
        read_cell(0, 0, v);
        n_checks++; if (v !== 2'b10) $display("FAIL simul_cell: got %b required 10", v); else n_pass++;
    endtask

    task automatic test_invalid();
        int base;
        logic [1:0] v;
        base = n_pulses;
        drive_event(1'b1, 1'b0, 9, 1);
        drive_event(1'b0, 1'b1, 9, 1);
        drive_event(1'b1, 1'b0, 3, 0);
        @(negedge clk);
        n_checks++; if (n_pulses !== base || flags_left !== 8'd9) $display("FAIL invalid_ignored: got pulses=%0d flags=%0d required 0/9", n_pulses - base, flags_left); else n_pass++;
        read_cell(8, 0, v);
        n_checks++; if (v !== 2'b00) $display("FAIL invalid_cell: got %b required 00", v); else n_pass++;
    endtask

    task automatic test_busy_drop();
        int base;
        logic [1:0] v;
        base = n_pulses;
        bx = 5'd4; by = 5'd4; flag = 1'b1;
        @(negedge clk); flag = 1'b0;
        @(negedge clk); bx = 5'd6; by = 5'd6; bomb = 1'b1;
        repeat (4) @(negedge clk);
        bomb = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (n_pulses !== base || flags_left !== 8'd8) $display("FAIL busy_drop: got pulses=%0d flags=%0d required 0/8", n_pulses - base, flags_left); else n_pass++;
        read_cell(5, 5, v);
        n_checks++; if (v !== 2'b00) $display("FAIL busy_drop_cell: got %b required 00", v); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base;
        logic b4;
        logic [1:0] v;
        base = n_pulses;
        bx = 5'd7; by = 5'd7; flag = 1'b1;
        @(negedge clk); flag = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back({5'd7, 5'd8});
        bx = 5'd7; by = 5'd8; bomb = 1'b1;
        @(negedge clk); b4 = busy; bomb = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (b4 !== 1'b1) $display("FAIL b2b_accept: got busy=%b required 1", b4); else n_pass++;
        n_checks++; if (n_pulses - base !== 1 || flags_left !== 8'd7) $display("FAIL b2b_result: got pulses=%0d flags=%0d required 1/7", n_pulses - base, flags_left); else n_pass++;
        read_cell(6, 6, v);
        n_checks++; if (v !== 2'b01) $display("FAIL b2b_cell_flag: got %b required 01", v); else n_pass++;
        read_cell(6, 7, v);
        n_checks++; if (v !== 2'b10) $display("FAIL b2b_cell_bomb: got %b required 10", v); else n_pass++;
    endtask

    task automatic test_no_flags();
        int cyc;
        logic [1:0] v;
        do_new_game(8'd1, cyc);
        drive_event(1'b0, 1'b1, 1, 1);
        n_checks++; if (flags_left !== 8'd0) $display("FAIL nf_first: got %0d required 0", flags_left); else n_pass++;
        drive_event(1'b0, 1'b1, 1, 2);
        n_checks++; if (flags_left !== 8'd0) $display("FAIL nf_exhausted: got %0d required 0", flags_left); else n_pass++;
        read_cell(0, 1, v);
        n_checks++; if (v !== 2'b00) $display("FAIL nf_cell: got %b required 00", v); else n_pass++;
        drive_event(1'b0, 1'b1, 1, 1);
        n_checks++; if (flags_left !== 8'd1) $display("FAIL nf_return: got %0d required 1", flags_left); else n_pass++;
    endtask

    task automatic test_new_game_mid();
        int cyc, base;
        logic [1:0] v;
        do_new_game(8'd5, cyc);
        base = n_pulses;
        bx = 5'd6; by = 5'd6; bomb = 1'b1;
        @(negedge clk); bomb = 1'b0;
        @(negedge clk); new_game = 1'b1; mine_count = 8'd5;
        @(negedge clk); new_game = 1'b0;
        n_checks++; if ({busy, reveal_valid} !== 2'b10 || flags_left !== 8'd5) $display("FAIL ngmid_abort: got busy=%b valid=%b flags=%0d required 1/0/5", busy, reveal_valid, flags_left); else n_pass++;
        repeat (100) @(negedge clk);
        mine_count = 8'd3; new_game = 1'b1;
        @(negedge clk); new_game = 1'b0;
        wait_idle(cyc);
        n_checks++; if (cyc !== 256) $display("FAIL ngmid_restart: got %0d required 256", cyc); else n_pass++;
        n_checks++; if (flags_left !== 8'd3 || n_pulses !== base) $display("FAIL ngmid_state: got flags=%0d pulses=%0d required 3/0", flags_left, n_pulses - base); else n_pass++;
        read_cell(5, 5, v);
        n_checks++; if (v !== 2'b00) $display("FAIL ngmid_cell: got %b required 00", v); else n_pass++;
        // Reset while an event is in flight.
        bx = 5'd8; by = 5'd8; bomb = 1'b1;
        @(negedge clk); bomb = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        wait_idle(cyc);
        read_cell(7, 7, v);
        n_checks++; if (v !== 2'b00 || n_pulses !== base || flags_left !== 8'd0) $display("FAIL rst_mid: got cell=%b pulses=%0d flags=%0d required 00/0/0", v, n_pulses - base, flags_left); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_flag();
        test_bomb_held();
        test_flag_bomb();
        test_simultaneous();
        test_invalid();
        test_busy_drop();
        test_back_to_back();
        test_no_flags();
        test_new_game_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
